// File: rtl/koa_mult_share_ctrl.sv
// Shares one pipelined Karatsuba multiplier between two requesters: round-robin issue,
// fixed-latency tag pipe, and credit-protected per-requester result FIFOs.
module koa_mult_share_ctrl #(
  parameter int unsigned SW         = 24,
  parameter int unsigned MUL_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [SW-1:0]   req0_a_i,
  input  logic [SW-1:0]   req0_b_i,
  output logic            res0_valid_o,
  input  logic            res0_ready_i,
  output logic [2*SW-1:0] res0_p_o,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [SW-1:0]   req1_a_i,
  input  logic [SW-1:0]   req1_b_i,
  output logic            res1_valid_o,
  input  logic            res1_ready_i,
  output logic [2*SW-1:0] res1_p_o,
  output logic [SW-1:0]   mul_a_o,
  output logic [SW-1:0]   mul_b_o,
  input  logic [2*SW-1:0] mul_p_i,
  output logic            busy_o
);

  localparam int unsigned PW = 2 * SW;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]       req_valid;
  logic [1:0]       res_ready;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       res_valid;
  logic [PW-1:0]    res_p [2];
  logic             rr_ptr;
  logic             issue;
  logic             gid;
  logic [MUL_LAT:0] tag_v;
  logic [MUL_LAT:0] tag_id;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign res_ready = {res1_ready_i, res0_ready_i};

  // Round-robin: with both eligible, the requester not named by rr_ptr wins
  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) begin
      grant = rr_ptr ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
  end

  assign issue        = |grant;
  assign gid          = grant[1];
  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  // Operand registers, tag pipe and arbitration pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_o <= '0;
      mul_b_o <= '0;
      tag_v   <= '0;
      tag_id  <= '0;
      rr_ptr  <= 1'b1;
    end else begin
      tag_v  <= {tag_v[MUL_LAT-1:0], issue};
      tag_id <= {tag_id[MUL_LAT-1:0], gid};
      if (issue) begin
        mul_a_o <= gid ? req1_a_i : req0_a_i;
        mul_b_o <= gid ? req1_b_i : req0_b_i;
        rr_ptr  <= gid;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_res
    logic [PW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign elig[g]      = rst_n && req_valid[g] && (cnt < CW'(FIFO_DEPTH));
    assign push[g]      = tag_v[MUL_LAT] && (tag_id[MUL_LAT] == 1'(g));
    assign pop[g]       = !empty && res_ready[g];
    assign res_valid[g] = !empty;
    assign res_p[g]     = mem[rd_ptr[AW-1:0]];

    // Credits count FIFO occupancy plus in-flight ops, so a push always finds room
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        assert (!(push[g] && full && !pop[g]));
        if (push[g]) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop[g])  rd_ptr <= rd_ptr + (AW+1)'(1);
        case ({grant[g], pop[g]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr[AW-1:0]] <= mul_p_i;
    end
  end

  assign res0_valid_o = res_valid[0];
  assign res1_valid_o = res_valid[1];
  assign res0_p_o     = res_p[0];
  assign res1_p_o     = res_p[1];
  assign busy_o       = (|tag_v) || (|res_valid);

endmodule

// File: tb/tb_koa_mult_share_ctrl.sv
// Directed bench for koa_mult_share_ctrl with a one-cycle registered multiplier model.
module tb_koa_mult_share_ctrl;
  localparam int unsigned SW = 24;
  localparam int unsigned PW = 48;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid_i, req0_ready_o, res0_valid_o, res0_ready_i;
  logic          req1_valid_i, req1_ready_o, res1_valid_o, res1_ready_i;
  logic [SW-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i, mul_a_o, mul_b_o;
  logic [PW-1:0] res0_p_o, res1_p_o, mul_p_i;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Multiplier model: product registered one cycle after operands change
  always_ff @(posedge clk) mul_p_i <= PW'(mul_a_o) * PW'(mul_b_o);

  koa_mult_share_ctrl #(.SW(24), .MUL_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .res0_valid_o(res0_valid_o), .res0_ready_i(res0_ready_i), .res0_p_o(res0_p_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .res1_valid_o(res1_valid_o), .res1_ready_i(res1_ready_i), .res1_p_o(res1_p_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_p_i(mul_p_i), .busy_o(busy_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; res0_ready_i = 1'b0;
    req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0; res1_ready_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (req0_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %0b expected 0", req0_ready_o); end
    n_checks++; if (req1_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %0b expected 0", req1_ready_o); end
    n_checks++; if (res0_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %0b expected 0", res0_valid_o); end
    n_checks++; if (res1_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %0b expected 0", res1_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
    n_checks++; if (mul_a_o !== 24'h0) begin n_fail++; $display("FAIL reset_mul_a: got %0h expected 0", mul_a_o); end
    n_checks++; if (mul_b_o !== 24'h0) begin n_fail++; $display("FAIL reset_mul_b: got %0h expected 0", mul_b_o); end
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_basic;
    req0_valid_i = 1'b1; req0_a_i = 24'd3; req0_b_i = 24'd5; #1;
    n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready0: got %0b expected 1", req0_ready_o); end
    n_checks++; if (req1_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_ready1: got %0b expected 0", req1_ready_o); end
    tick();
    req0_valid_i = 1'b0; #1;
    n_checks++; if (mul_a_o !== 24'd3) begin n_fail++; $display("FAIL basic_mul_a: got %0h expected 3", mul_a_o); end
    n_checks++; if (mul_b_o !== 24'd5) begin n_fail++; $display("FAIL basic_mul_b: got %0h expected 5", mul_b_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b expected 1", busy_o); end
    n_checks++; if (res0_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid_e0: got %0b expected 0", res0_valid_o); end
    tick(); #1;
    n_checks++; if (res0_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid_e1: got %0b expected 0", res0_valid_o); end
    tick(); #1;
    n_checks++; if (res0_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid0: got %0b expected 1", res0_valid_o); end
    n_checks++; if (res0_p_o !== 48'd15) begin n_fail++; $display("FAIL basic_product: got %0h expected f", res0_p_o); end
    n_checks++; if (res1_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid1: got %0b expected 0", res1_valid_o); end
    res0_ready_i = 1'b1;
    tick(); #1;
    n_checks++; if (res0_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid0: got %0b expected 0", res0_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %0b expected 0", busy_o); end
    res0_ready_i = 1'b0;
  endtask

  task automatic test_alternate;
    int i0 = 0, i1 = 0, g0 = 0, g1 = 0;
    do_reset();
    res0_ready_i = 1'b1; res1_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req0_valid_i = 1'b1; req0_a_i = SW'(i0 + 1); req0_b_i = 24'd1;
      req1_valid_i = 1'b1; req1_a_i = SW'(i1 + 1); req1_b_i = 24'd2;
      #1;
      n_checks++; if (req0_ready_o !== 1'(c % 2 == 0)) begin n_fail++; $display("FAIL alt_ready0 c=%0d: got %0b expected %0b", c, req0_ready_o, c % 2 == 0); end
      n_checks++; if (req1_ready_o !== 1'(c % 2 == 1)) begin n_fail++; $display("FAIL alt_ready1 c=%0d: got %0b expected %0b", c, req1_ready_o, c % 2 == 1); end
      if (req0_ready_o) i0++;
      if (req1_ready_o) i1++;
      if (res0_valid_o) begin
        n_checks++; if (res0_p_o !== PW'(g0 + 1)) begin n_fail++; $display("FAIL alt_res0 #%0d: got %0h expected %0h", g0, res0_p_o, g0 + 1); end
        g0++;
      end
      if (res1_valid_o) begin
        n_checks++; if (res1_p_o !== PW'(2 * (g1 + 1))) begin n_fail++; $display("FAIL alt_res1 #%0d: got %0h expected %0h", g1, res1_p_o, 2 * (g1 + 1)); end
        g1++;
      end
      tick();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (res0_valid_o) begin
        n_checks++; if (res0_p_o !== PW'(g0 + 1)) begin n_fail++; $display("FAIL alt_res0 #%0d: got %0h expected %0h", g0, res0_p_o, g0 + 1); end
        g0++;
      end
      if (res1_valid_o) begin
        n_checks++; if (res1_p_o !== PW'(2 * (g1 + 1))) begin n_fail++; $display("FAIL alt_res1 #%0d: got %0h expected %0h", g1, res1_p_o, 2 * (g1 + 1)); end
        g1++;
      end
      tick();
    end
    n_checks++; if (g0 != 4) begin n_fail++; $display("FAIL alt_count0: got %0d expected 4", g0); end
    n_checks++; if (g1 != 4) begin n_fail++; $display("FAIL alt_count1: got %0d expected 4", g1); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL alt_busy: got %0b expected 0", busy_o); end
  endtask

  task automatic test_backpressure;
    int i0 = 0, i1 = 0, g0 = 0, g1 = 0;
    do_reset();
    res0_ready_i = 1'b0; res1_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req0_valid_i = 1'b1; req0_a_i = SW'(i0 + 1); req0_b_i = 24'd3;
      req1_valid_i = 1'b1; req1_a_i = SW'(i1 + 1); req1_b_i = 24'd1;
      #1;
      n_checks++; if (req0_ready_o !== 1'(c < 7 && c % 2 == 0)) begin n_fail++; $display("FAIL bp_ready0 c=%0d: got %0b", c, req0_ready_o); end
      n_checks++; if (req1_ready_o !== 1'(c % 2 == 1 || c >= 7)) begin n_fail++; $display("FAIL bp_ready1 c=%0d: got %0b", c, req1_ready_o); end
      if (req0_ready_o) i0++;
      if (req1_ready_o) i1++;
      if (res1_valid_o) begin
        n_checks++; if (res1_p_o !== PW'(g1 + 1)) begin n_fail++; $display("FAIL bp_res1 #%0d: got %0h expected %0h", g1, res1_p_o, g1 + 1); end
        g1++;
      end
      tick();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; res0_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (res0_valid_o) begin
        n_checks++; if (res0_p_o !== PW'(3 * (g0 + 1))) begin n_fail++; $display("FAIL bp_res0 #%0d: got %0h expected %0h", g0, res0_p_o, 3 * (g0 + 1)); end
        g0++;
      end
      if (res1_valid_o) begin
        n_checks++; if (res1_p_o !== PW'(g1 + 1)) begin n_fail++; $display("FAIL bp_res1 #%0d: got %0h expected %0h", g1, res1_p_o, g1 + 1); end
        g1++;
      end
      tick();
    end
    n_checks++; if (i0 != 4) begin n_fail++; $display("FAIL bp_hs0: got %0d expected 4", i0); end
    n_checks++; if (g0 != 4) begin n_fail++; $display("FAIL bp_count0: got %0d expected 4", g0); end
    n_checks++; if (g1 != 8) begin n_fail++; $display("FAIL bp_count1: got %0d expected 8", g1); end
    res0_ready_i = 1'b0; res1_ready_i = 1'b0;
  endtask

  task automatic test_full_pop;
    logic [PW-1:0] exp_p [4];
    int n = 0;
    exp_p[0] = 48'd22; exp_p[1] = 48'd24; exp_p[2] = 48'd26; exp_p[3] = 48'd100;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req0_valid_i = 1'b1; req0_a_i = SW'(10 + c); req0_b_i = 24'd2; #1;
      n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready c=%0d: got %0b expected 1", c, req0_ready_o); end
      tick();
    end
    req0_valid_i = 1'b0;
    tick(); tick(); tick();
    req0_valid_i = 1'b1; req0_a_i = 24'd50; req0_b_i = 24'd2; res0_ready_i = 1'b1; #1;
    n_checks++; if (req0_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_issue: got %0b expected 0", req0_ready_o); end
    n_checks++; if (res0_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %0b expected 1", res0_valid_o); end
    n_checks++; if (res0_p_o !== 48'd20) begin n_fail++; $display("FAIL full_head: got %0h expected 14", res0_p_o); end
    tick();
    res0_ready_i = 1'b0; #1;
    n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_next_issue: got %0b expected 1", req0_ready_o); end
    tick();
    req0_valid_i = 1'b0; res0_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (res0_valid_o) begin
        n_checks++;
        if (n >= 4) begin n_fail++; $display("FAIL full_extra_result: got %0h", res0_p_o); end
        else if (res0_p_o !== exp_p[n]) begin n_fail++; $display("FAIL full_res #%0d: got %0h expected %0h", n, res0_p_o, exp_p[n]); end
        n++;
      end
      tick();
    end
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", n); end
    res0_ready_i = 1'b0;
  endtask

  task automatic test_extremes;
    int g0 = 0, g1 = 0;
    logic [PW-1:0] exp0 [2];
    exp0[0] = 48'h0; exp0[1] = 48'h1FFFFFE;
    do_reset();
    res0_ready_i = 1'b1; res1_ready_i = 1'b1;
    req1_valid_i = 1'b1; req1_a_i = 24'hFFFFFF; req1_b_i = 24'hFFFFFF; #1;
    n_checks++; if (req1_ready_o !== 1'b1) begin n_fail++; $display("FAIL ext_ready1: got %0b expected 1", req1_ready_o); end
    tick();
    req1_valid_i = 1'b0;
    req0_valid_i = 1'b1; req0_a_i = 24'h0; req0_b_i = 24'hABCDEF; #1;
    n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL ext_ready0a: got %0b expected 1", req0_ready_o); end
    tick();
    req0_a_i = 24'hFFFFFF; req0_b_i = 24'd2; #1;
    n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL ext_ready0b: got %0b expected 1", req0_ready_o); end
    tick();
    req0_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (res1_valid_o) begin
        n_checks++; if (res1_p_o !== 48'hFFFFFE000001) begin n_fail++; $display("FAIL ext_max_product: got %0h expected fffffe000001", res1_p_o); end
        g1++;
      end
      if (res0_valid_o) begin
        n_checks++;
        if (g0 >= 2) begin n_fail++; $display("FAIL ext_extra_res0: got %0h", res0_p_o); end
        else if (res0_p_o !== exp0[g0]) begin n_fail++; $display("FAIL ext_res0 #%0d: got %0h expected %0h", g0, res0_p_o, exp0[g0]); end
        g0++;
      end
      tick();
    end
    n_checks++; if (g0 != 2) begin n_fail++; $display("FAIL ext_count0: got %0d expected 2", g0); end
    n_checks++; if (g1 != 1) begin n_fail++; $display("FAIL ext_count1: got %0d expected 1", g1); end
    res0_ready_i = 1'b0; res1_ready_i = 1'b0;
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req1_valid_i = 1'b1; req1_a_i = SW'(c + 1); req1_b_i = 24'd1; #1;
      n_checks++; if (req1_ready_o !== 1'b1) begin n_fail++; $display("FAIL mr_fill c=%0d: got %0b expected 1", c, req1_ready_o); end
      tick();
    end
    req1_valid_i = 1'b0;
    tick(); tick(); tick();
    req0_valid_i = 1'b1; req0_a_i = 24'd1; req0_b_i = 24'd1;
    req1_valid_i = 1'b1; req1_a_i = 24'd9; req1_b_i = 24'd9; #1;
    n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL mr_grant0: got %0b expected 1", req0_ready_o); end
    tick(); #1;
    n_checks++; if (req1_ready_o !== 1'b1) begin n_fail++; $display("FAIL mr_grant1: got %0b expected 1", req1_ready_o); end
    tick();
    rst_n = 1'b0;
    tick(); #1;
    n_checks++; if (req0_ready_o !== 1'b0) begin n_fail++; $display("FAIL mr_ready0: got %0b expected 0", req0_ready_o); end
    n_checks++; if (req1_ready_o !== 1'b0) begin n_fail++; $display("FAIL mr_ready1: got %0b expected 0", req1_ready_o); end
    n_checks++; if (res0_valid_o !== 1'b0) begin n_fail++; $display("FAIL mr_valid0: got %0b expected 0", res0_valid_o); end
    n_checks++; if (res1_valid_o !== 1'b0) begin n_fail++; $display("FAIL mr_valid1: got %0b expected 0", res1_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %0b expected 0", busy_o); end
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      n_checks++; if ({res0_valid_o, res1_valid_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL mr_stale k=%0d: got %03b expected 000", k, {res0_valid_o, res1_valid_o, busy_o}); end
    end
    tick();
    req0_valid_i = 1'b1; req0_a_i = 24'd7; req0_b_i = 24'd6; #1;
    n_checks++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL mr_post_ready: got %0b expected 1", req0_ready_o); end
    tick();
    req0_valid_i = 1'b0;
    tick(); tick(); #1;
    n_checks++; if (res0_valid_o !== 1'b1) begin n_fail++; $display("FAIL mr_post_valid: got %0b expected 1", res0_valid_o); end
    n_checks++; if (res0_p_o !== 48'd42) begin n_fail++; $display("FAIL mr_post_product: got %0h expected 2a", res0_p_o); end
    n_checks++; if (res1_valid_o !== 1'b0) begin n_fail++; $display("FAIL mr_post_valid1: got %0b expected 0", res1_valid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_basic();
    test_alternate();
    test_backpressure();
    test_full_pop();
    test_extremes();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
